dcache_refill_sched: RTL and testbench
======================================

Name: dcache_refill_sched

Overview:
Refill scheduler for the L1 D-cache miss path.
- Arbitrates round-robin among the MSHRs for the single memory acquire channel.
- Sequences the returned grant beats into the data array write port, one row per beat.
- Reports completion to the owning MSHR.
- Only one refill is in flight at a time. Sits between the MSHR file, the outer memory channel and the data array.

Parameters:
N_MSHRS, 4, number of requesting MSHRs
REFILL_BEATS, 4, grant beats per cache block (blockBytes*8/ROW_BITS)
IDX_BITS, 6, set index width (64 sets)
WAY_BITS, 3, way select width (8 ways)
TAG_BITS, 20, physical tag width
ROW_BITS, 128, data array row / beat width
TIMEOUT, 255, watchdog limit in cycles (optional feature only)

Ports:
clock  in  1  clock
reset_n  in  1  synchronous active-low reset
req_valid  in  N_MSHRS  per-MSHR refill request
req_tag  in  N_MSHRS*TAG_BITS  per-MSHR tag
req_idx  in  N_MSHRS*IDX_BITS  per-MSHR set index
req_way  in  N_MSHRS*WAY_BITS  per-MSHR victim way
req_grant  out  N_MSHRS  one-hot, 1-cycle accept pulse
mem_acq_valid  out  1  acquire request
mem_acq_ready  in  1  acquire accepted
mem_acq_addr  out  TAG_BITS+IDX_BITS  block address {tag,idx}
mem_acq_id  out  clog2(N_MSHRS)  source id
mem_gnt_valid  in  1  grant beat valid
mem_gnt_ready  out  1  grant beat accepted
mem_gnt_id  in  clog2(N_MSHRS)  grant source id
mem_gnt_data  in  ROW_BITS  beat data
data_wr_en  out  1  data array row write
data_wr_ready  in  1  data array free (CPU port has priority)
data_wr_way  out  WAY_BITS  write way
data_wr_idx  out  IDX_BITS  write set
data_wr_beat  out  clog2(REFILL_BEATS)  row within block
data_wr_data  out  ROW_BITS  write data
done_valid  out  1  refill complete pulse
done_id  out  clog2(N_MSHRS)  completed MSHR
err  out  1  sticky protocol error
busy  out  1  state != IDLE

Behaviour:
- Reset (reset_n low at a rising edge):
  - state=IDLE, RR pointer=0, beat counter=0, err=0.
  - All outputs are 0 one cycle later.
  - Reset mid-refill aborts with no done_valid. Data rows already written stay written.
- States: IDLE, ACQ, BEAT, DONE.
- IDLE:
  - If any req_valid, grant the first requester at or after the RR pointer, wrapping modulo N_MSHRS.
  - req_grant pulses for that cycle. Latch tag/idx/way/id. RR pointer := granted+1 mod N_MSHRS. Next state ACQ.
  - Grant is combinational from req_valid in IDLE (0-cycle request-to-grant).
- ACQ:
  - mem_acq_valid=1 with the latched address and id. Held stable until mem_acq_ready.
  - Handshake cycle -> BEAT, beat counter=0.
- BEAT:
  - mem_gnt_ready = data_wr_ready && (mem_gnt_id==cur_id).
  - data_wr_en = mem_gnt_valid && mem_gnt_ready. data_wr_way/idx come from the latch; data_wr_beat = counter; data_wr_data = mem_gnt_data (combinational pass-through, no added latency).
  - Each write increments the counter. The write with counter == REFILL_BEATS-1 -> DONE, counter wraps to 0.
  - Valid beat with id != cur_id: not accepted, err set sticky, state unchanged.
  - data_wr_ready low stalls with no data loss.
- DONE:
  - done_valid=1 and done_id=cur_id for exactly one cycle, then IDLE.
  - No grant in DONE. Minimum spacing between grants = REFILL_BEATS+3 cycles.
- An MSHR dropping req_valid before grant is legal. Inputs are sampled only in IDLE.
- err is cleared only by reset.

Optional Feature:
DCACHE_REFILL_TIMEOUT_EN:
- Defined: an 8-bit watchdog counts cycles in ACQ/BEAT without a handshake and resets on each handshake.
  - Reaching TIMEOUT sets err and forces DONE. done_valid pulses normally.
  - Remaining beats are not written.
- Undefined: no watchdog. The FSM waits indefinitely and TIMEOUT is unused.

Test Plan:
- Single request: MSHR2 valid, tag=0x12345, idx=5, way=3; acq_ready=1; 4 beats D0..D3 id=2 back-to-back -> grant[2] pulse; acq_addr=0x12345_05; data_wr beats 0..3 at idx 5 way 3; done_valid id=2 exactly one cycle after last beat.
- Round-robin: all 4 req_valid held -> grant order 0,1,2,3,0. Then only MSHR1 valid with pointer=1 -> grant 1.
- Backpressure: data_wr_ready low for 3 cycles mid-beat-1 -> mem_gnt_ready low for those cycles; exactly 4 writes, beats 0..3 in order, data unchanged.
- Wrong id: beat with id=1 while cur_id=0 -> not accepted, err=1; correct-id beats still complete refill.
- Reset mid-refill: reset_n low after beat 1 -> next cycle busy=0, all outputs 0, no done_valid. New request is granted after reset with RR pointer=0.
- Timeout (macro defined): acq accepted, no gnt for 255 cycles -> err=1, done_valid pulse, state IDLE.

Source files
------------

// File: rtl/dcache_refill_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dcache_refill_sched
//
// Refill scheduler for the L1 D-cache miss path. Picks one MSHR round-robin,
// issues its block acquire on the outer memory channel, then streams the
// returned grant beats into the data array write port (one row per beat)
// and signals completion back to the owning MSHR. Only one refill is in
// flight at any time.
//
// Ports:
//   clock, reset_n                 clock, synchronous active-low reset
//   req_valid/tag/idx/way          per-MSHR refill requests (packed, MSHR0 at LSBs)
//   req_grant                      one-hot 1-cycle accept pulse (combinational in IDLE)
//   mem_acq_valid/ready/addr/id    acquire channel, addr = {tag, idx}
//   mem_gnt_valid/ready/id/data    grant beat channel
//   data_wr_en/ready/way/idx/beat/data  data array row write port
//   done_valid, done_id            refill complete pulse
//   err                            sticky protocol error (wrong-id beat, watchdog)
//   busy                           scheduler not idle
//
// Optional build macro:
//   DCACHE_REFILL_TIMEOUT_EN       enables an 8-bit watchdog over ACQ/BEAT; when
//                                  TIMEOUT cycles pass without a handshake the
//                                  refill is abandoned (err set, DONE pulsed).
// -----------------------------------------------------------------------------
module dcache_refill_sched #(
  parameter int unsigned N_MSHRS      = 4,
  parameter int unsigned REFILL_BEATS = 4,
  parameter int unsigned IDX_BITS     = 6,
  parameter int unsigned WAY_BITS     = 3,
  parameter int unsigned TAG_BITS     = 20,
  parameter int unsigned ROW_BITS     = 128,
  parameter int unsigned TIMEOUT      = 255,
  localparam int unsigned ID_W        = (N_MSHRS > 1) ? $clog2(N_MSHRS) : 1,
  localparam int unsigned BEAT_W      = (REFILL_BEATS > 1) ? $clog2(REFILL_BEATS) : 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [N_MSHRS-1:0]            req_valid,
  input  logic [N_MSHRS*TAG_BITS-1:0]   req_tag,
  input  logic [N_MSHRS*IDX_BITS-1:0]   req_idx,
  input  logic [N_MSHRS*WAY_BITS-1:0]   req_way,
  output logic [N_MSHRS-1:0]            req_grant,
  output logic                          mem_acq_valid,
  input  logic                          mem_acq_ready,
  output logic [TAG_BITS+IDX_BITS-1:0]  mem_acq_addr,
  output logic [ID_W-1:0]               mem_acq_id,
  input  logic                          mem_gnt_valid,
  output logic                          mem_gnt_ready,
  input  logic [ID_W-1:0]               mem_gnt_id,
  input  logic [ROW_BITS-1:0]           mem_gnt_data,
  output logic                          data_wr_en,
  input  logic                          data_wr_ready,
  output logic [WAY_BITS-1:0]           data_wr_way,
  output logic [IDX_BITS-1:0]           data_wr_idx,
  output logic [BEAT_W-1:0]             data_wr_beat,
  output logic [ROW_BITS-1:0]           data_wr_data,
  output logic                          done_valid,
  output logic [ID_W-1:0]               done_id,
  output logic                          err,
  output logic                          busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACQ  = 2'd1;
  localparam logic [1:0] S_BEAT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [BEAT_W-1:0]   cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [TAG_BITS-1:0] tag_q, tag_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic [WAY_BITS-1:0] way_q, way_d;

`ifdef DCACHE_REFILL_TIMEOUT_EN
  logic [7:0]          wdog_q, wdog_d;
`endif

  // Round-robin pick: first requester at or after rr_q, wrapping.
  logic                arb_hit;
  logic [ID_W-1:0]     arb_id;
  logic [ID_W-1:0]     arb_cand;

  always_comb begin
    arb_hit  = 1'b0;
    arb_id   = '0;
    arb_cand = '0;
    for (int unsigned i = 0; i < N_MSHRS; i++) begin
      arb_cand = ID_W'((32'(rr_q) + i) % N_MSHRS);
      if (!arb_hit && req_valid[arb_cand]) begin
        arb_hit = 1'b1;
        arb_id  = arb_cand;
      end
    end
  end

  logic in_idle, in_acq, in_beat, in_done;
  logic grant_fire, acq_fire, wr_fire, bad_beat, last_beat;

  assign in_idle = (state_q == S_IDLE);
  assign in_acq  = (state_q == S_ACQ);
  assign in_beat = (state_q == S_BEAT);
  assign in_done = (state_q == S_DONE);

  // A grant raised while reset is asserted would be dropped by the reset,
  // so it is suppressed to keep the MSHR from believing it was accepted.
  assign grant_fire = in_idle && reset_n && arb_hit;
  assign acq_fire   = in_acq && mem_acq_ready;
  assign wr_fire    = mem_gnt_valid && mem_gnt_ready;
  assign bad_beat   = in_beat && mem_gnt_valid && (mem_gnt_id != id_q);
  assign last_beat  = (cnt_q == BEAT_W'(REFILL_BEATS - 1));

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    id_d    = id_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    way_d   = way_q;

    case (state_q)
      S_IDLE: begin
        if (grant_fire) begin
          id_d    = arb_id;
          tag_d   = req_tag[arb_id*TAG_BITS +: TAG_BITS];
          idx_d   = req_idx[arb_id*IDX_BITS +: IDX_BITS];
          way_d   = req_way[arb_id*WAY_BITS +: WAY_BITS];
          rr_d    = (arb_id == ID_W'(N_MSHRS - 1)) ? '0 : arb_id + 1'b1;
          state_d = S_ACQ;
        end
      end
      S_ACQ: begin
        if (acq_fire) begin
          cnt_d   = '0;
          state_d = S_BEAT;
        end
      end
      S_BEAT: begin
        // A beat for another source is left on the channel, not consumed.
        if (bad_beat) begin
          err_d = 1'b1;
        end
        if (wr_fire) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef DCACHE_REFILL_TIMEOUT_EN
    // Watchdog overrides the normal transition: abandon the refill and
    // report completion so the MSHR is not left hanging.
    wdog_d = '0;
    if (in_acq || in_beat) begin
      if (acq_fire || wr_fire) begin
        wdog_d = '0;
      end else if (wdog_q == 8'(TIMEOUT - 1)) begin
        wdog_d  = '0;
        err_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_DONE;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      id_q    <= '0;
      tag_q   <= '0;
      idx_q   <= '0;
      way_q   <= '0;
`ifdef DCACHE_REFILL_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      id_q    <= id_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      way_q   <= way_d;
`ifdef DCACHE_REFILL_TIMEOUT_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  // Outputs are qualified by state so everything reads 0 while idle.
  assign req_grant     = grant_fire ? (N_MSHRS'(1) << arb_id) : '0;

  assign mem_acq_valid = in_acq;
  assign mem_acq_addr  = in_acq ? {tag_q, idx_q} : '0;
  assign mem_acq_id    = in_acq ? id_q : '0;

  assign mem_gnt_ready = in_beat && data_wr_ready && (mem_gnt_id == id_q);

  assign data_wr_en    = wr_fire;
  assign data_wr_way   = in_beat ? way_q : '0;
  assign data_wr_idx   = in_beat ? idx_q : '0;
  assign data_wr_beat  = in_beat ? cnt_q : '0;
  assign data_wr_data  = in_beat ? mem_gnt_data : '0;

  assign done_valid    = in_done;
  assign done_id       = in_done ? id_q : '0;

  assign err           = err_q;
  assign busy          = !in_idle;

endmodule

// File: tb/tb_dcache_refill_sched.sv
`timescale 1ns/1ps
module tb_dcache_refill_sched;

  localparam int N     = 4;
  localparam int BEATS = 4;
  localparam int IDXB  = 6;
  localparam int WAYB  = 3;
  localparam int TAGB  = 20;
  localparam int ROWB  = 128;
  localparam int IDW   = 2;
  localparam int BW    = 2;

  logic                 clock;
  logic                 reset_n;
  logic [N-1:0]         req_valid;
  logic [N*TAGB-1:0]    req_tag;
  logic [N*IDXB-1:0]    req_idx;
  logic [N*WAYB-1:0]    req_way;
  logic [N-1:0]         req_grant;
  logic                 mem_acq_valid;
  logic                 mem_acq_ready;
  logic [TAGB+IDXB-1:0] mem_acq_addr;
  logic [IDW-1:0]       mem_acq_id;
  logic                 mem_gnt_valid;
  logic                 mem_gnt_ready;
  logic [IDW-1:0]       mem_gnt_id;
  logic [ROWB-1:0]      mem_gnt_data;
  logic                 data_wr_en;
  logic                 data_wr_ready;
  logic [WAYB-1:0]      data_wr_way;
  logic [IDXB-1:0]      data_wr_idx;
  logic [BW-1:0]        data_wr_beat;
  logic [ROWB-1:0]      data_wr_data;
  logic                 done_valid;
  logic [IDW-1:0]       done_id;
  logic                 err;
  logic                 busy;

  dcache_refill_sched #(
    .N_MSHRS(N), .REFILL_BEATS(BEATS), .IDX_BITS(IDXB), .WAY_BITS(WAYB),
    .TAG_BITS(TAGB), .ROW_BITS(ROWB), .TIMEOUT(255)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_tag(req_tag), .req_idx(req_idx), .req_way(req_way),
    .req_grant(req_grant),
    .mem_acq_valid(mem_acq_valid), .mem_acq_ready(mem_acq_ready),
    .mem_acq_addr(mem_acq_addr), .mem_acq_id(mem_acq_id),
    .mem_gnt_valid(mem_gnt_valid), .mem_gnt_ready(mem_gnt_ready),
    .mem_gnt_id(mem_gnt_id), .mem_gnt_data(mem_gnt_data),
    .data_wr_en(data_wr_en), .data_wr_ready(data_wr_ready),
    .data_wr_way(data_wr_way), .data_wr_idx(data_wr_idx),
    .data_wr_beat(data_wr_beat), .data_wr_data(data_wr_data),
    .done_valid(done_valid), .done_id(done_id),
    .err(err), .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_pass  = 0;
  int n_total = 0;
  bit mon_en  = 1'b0;
  int wr_count   = 0;
  int stall_leak = 0;

  logic [TAGB-1:0] t_tag [N];
  logic [IDXB-1:0] t_idx [N];
  logic [WAYB-1:0] t_way [N];

  int                           q_grant [$];
  logic [TAGB+IDXB+IDW-1:0]     q_acq   [$];
  logic [WAYB+IDXB+BW+ROWB-1:0] q_wr    [$];
  int                           q_done  [$];

  // Scoreboard monitor: compares every DUT event against the queued expectation.
  always @(negedge clock) begin
    int e;
    logic [N-1:0] eg;
    logic [TAGB+IDXB+IDW-1:0] ea;
    logic [WAYB+IDXB+BW+ROWB-1:0] ew;
    if (mon_en) begin
      if (req_grant !== '0) begin
        n_total++;
        if (q_grant.size() == 0) begin
          $display("FAIL grant: unexpected req_grant=%b", req_grant);
        end else begin
          e  = q_grant.pop_front();
          eg = 4'b0001 << e;
          if (req_grant !== eg) $display("FAIL grant: got %b expected %b", req_grant, eg);
          else n_pass++;
        end
      end
      if (mem_acq_valid === 1'b1 && mem_acq_ready === 1'b1) begin
        n_total++;
        if (q_acq.size() == 0) begin
          $display("FAIL acq: unexpected acquire addr=%h id=%0d", mem_acq_addr, mem_acq_id);
        end else begin
          ea = q_acq.pop_front();
          if ({mem_acq_addr, mem_acq_id} !== ea)
            $display("FAIL acq: got %h expected %h", {mem_acq_addr, mem_acq_id}, ea);
          else n_pass++;
        end
      end
      if (data_wr_en !== 1'b0) begin
        wr_count++;
        n_total++;
        if (q_wr.size() == 0) begin
          $display("FAIL wr: unexpected write beat=%0d data=%h", data_wr_beat, data_wr_data);
        end else begin
          ew = q_wr.pop_front();
          if ({data_wr_way, data_wr_idx, data_wr_beat, data_wr_data} !== ew)
            $display("FAIL wr: got %h expected %h",
                     {data_wr_way, data_wr_idx, data_wr_beat, data_wr_data}, ew);
          else n_pass++;
        end
      end
      if (done_valid !== 1'b0) begin
        n_total++;
        if (q_done.size() == 0) begin
          $display("FAIL done: unexpected done_valid id=%0d", done_id);
        end else begin
          e = q_done.pop_front();
          if (done_id !== IDW'(e)) $display("FAIL done: got id %0d expected %0d", done_id, e);
          else n_pass++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_refill(input int id, input bit with_done);
    q_grant.push_back(id);
    q_acq.push_back({t_tag[id], t_idx[id], IDW'(id)});
    if (with_done) q_done.push_back(id);
  endtask

  task automatic wait_grant();
    bit seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clock);
      if (req_grant !== '0) seen = 1'b1;
    end
    n_total++;
    if (!seen) $display("FAIL grant_wait: got no grant expected one within 50 cycles");
    else n_pass++;
  endtask

  // Drives nb beats; caller must be just after a rising edge.
  task automatic send_beats(input int id, input int nb, input int stall_beat);
    logic [ROWB-1:0] base;
    logic [ROWB-1:0] d;
    bit acc;
    base = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int b = 0; b < nb; b++) begin
      d = base + ROWB'(b);
      mem_gnt_valid = 1'b1;
      mem_gnt_id    = IDW'(id);
      mem_gnt_data  = d;
      q_wr.push_back({t_way[id], t_idx[id], BW'(b), d});
      if (b == stall_beat) begin
        data_wr_ready = 1'b0;
        repeat (3) begin
          @(negedge clock);
          if (mem_gnt_ready !== 1'b0 || data_wr_en !== 1'b0) stall_leak++;
        end
        tick();
        data_wr_ready = 1'b1;
      end
      acc = 1'b0;
      for (int k = 0; k < 60 && !acc; k++) begin
        @(negedge clock);
        if (mem_gnt_ready === 1'b1) acc = 1'b1;
      end
      n_total++;
      if (!acc) $display("FAIL beat_wait: beat %0d got no ready expected within 60 cycles", b);
      else n_pass++;
      tick();
    end
    mem_gnt_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    req_valid     = 4'hF;
    mem_acq_ready = 1'b1;
    mem_gnt_valid = 1'b0;
    mem_gnt_id    = '0;
    mem_gnt_data  = '1;
    data_wr_ready = 1'b1;
    tick();
    @(negedge clock);
    n_total++;
    if ({req_grant, mem_acq_valid, mem_acq_addr, mem_acq_id, mem_gnt_ready, data_wr_en,
         data_wr_way, data_wr_idx, data_wr_beat, data_wr_data, done_valid, done_id,
         err, busy} !== '0)
      $display("FAIL reset_outputs: got grant=%b acq=%b err=%b busy=%b expected all 0",
               req_grant, mem_acq_valid, err, busy);
    else n_pass++;
    mon_en = 1'b1;
    tick();
    req_valid = '0;
    reset_n   = 1'b1;
    @(negedge clock);
    n_total++;
    if (busy !== 1'b0 || err !== 1'b0) $display("FAIL reset_idle: got busy=%b err=%b expected 0 0", busy, err);
    else n_pass++;
    tick();
  endtask

  task automatic test_single();
    int w0;
    w0 = wr_count;
    req_valid = 4'b0100;
    expect_refill(2, 1);
    @(negedge clock);
    n_total++;
    if (req_grant !== 4'b0100) $display("FAIL single_grant: got %b expected 0100", req_grant);
    else n_pass++;
    tick();
    req_valid = '0;
    @(negedge clock);
    n_total++;
    if (mem_acq_valid !== 1'b1 || mem_acq_addr !== {20'h12345, 6'h05} || mem_acq_id !== 2'd2)
      $display("FAIL single_acq: got v=%b addr=%h id=%0d expected 1 %h 2",
               mem_acq_valid, mem_acq_addr, mem_acq_id, {20'h12345, 6'h05});
    else n_pass++;
    tick();
    send_beats(2, BEATS, -1);
    @(negedge clock);
    n_total++;
    if (done_valid !== 1'b1 || done_id !== 2'd2)
      $display("FAIL single_done: got v=%b id=%0d expected 1 2", done_valid, done_id);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (done_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL single_done_pulse: got v=%b busy=%b expected 0 0", done_valid, busy);
    else n_pass++;
    n_total++;
    if (wr_count - w0 !== 4) $display("FAIL single_wr_count: got %0d expected 4", wr_count - w0);
    else n_pass++;
    tick();
  endtask

  task automatic test_round_robin();
    int order [6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    req_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) req_valid = 4'b0010;
      expect_refill(order[i], 1);
      wait_grant();
      tick();
      if (i == 5) req_valid = '0;
      send_beats(order[i], BEATS, -1);
    end
    tick();
    @(negedge clock);
    n_total++;
    if (busy !== 1'b0 || q_grant.size() != 0)
      $display("FAIL rr_end: got busy=%b pending=%0d expected 0 0", busy, q_grant.size());
    else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    int w0;
    w0 = wr_count;
    stall_leak = 0;
    mem_acq_ready = 1'b0;
    req_valid = 4'b1000;
    expect_refill(3, 1);
    wait_grant();
    tick();
    req_valid = '0;
    repeat (3) begin
      @(negedge clock);
      n_total++;
      if (mem_acq_valid !== 1'b1 || {mem_acq_addr, mem_acq_id} !== {t_tag[3], t_idx[3], 2'd3})
        $display("FAIL acq_hold: got v=%b %h expected 1 %h", mem_acq_valid,
                 {mem_acq_addr, mem_acq_id}, {t_tag[3], t_idx[3], 2'd3});
      else n_pass++;
    end
    tick();
    mem_acq_ready = 1'b1;
    send_beats(3, BEATS, 1);
    n_total++;
    if (stall_leak !== 0) $display("FAIL bp_stall: got %0d accepting cycles expected 0", stall_leak);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (wr_count - w0 !== 4) $display("FAIL bp_wr_count: got %0d expected 4", wr_count - w0);
    else n_pass++;
  endtask

  task automatic test_wrong_id();
    req_valid = 4'b0001;
    expect_refill(0, 1);
    wait_grant();
    tick();
    req_valid = '0;
    tick();
    mem_gnt_valid = 1'b1;
    mem_gnt_id    = 2'd1;
    mem_gnt_data  = '1;
    @(negedge clock);
    n_total++;
    if (mem_gnt_ready !== 1'b0 || err !== 1'b0)
      $display("FAIL wrong_id_ready: got ready=%b err=%b expected 0 0", mem_gnt_ready, err);
    else n_pass++;
    tick();
    @(negedge clock);
    n_total++;
    if (err !== 1'b1 || mem_gnt_ready !== 1'b0)
      $display("FAIL wrong_id_err: got err=%b ready=%b expected 1 0", err, mem_gnt_ready);
    else n_pass++;
    tick();
    send_beats(0, BEATS, -1);
    @(negedge clock);
    n_total++;
    if (err !== 1'b1 || done_valid !== 1'b1)
      $display("FAIL wrong_id_sticky: got err=%b done=%b expected 1 1", err, done_valid);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0010;
    expect_refill(1, 0);
    wait_grant();
    tick();
    req_valid = '0;
    send_beats(1, 2, -1);
    reset_n   = 1'b0;
    req_valid = 4'b0101;
    tick();
    @(negedge clock);
    n_total++;
    if ({req_grant, mem_acq_valid, mem_acq_addr, mem_acq_id, mem_gnt_ready, data_wr_en,
         data_wr_way, data_wr_idx, data_wr_beat, data_wr_data, done_valid, done_id,
         err, busy} !== '0)
      $display("FAIL mid_reset_outputs: got busy=%b err=%b done=%b grant=%b expected all 0",
               busy, err, done_valid, req_grant);
    else n_pass++;
    tick();
    expect_refill(0, 1);
    reset_n = 1'b1;
    wait_grant();
    tick();
    req_valid = '0;
    send_beats(0, BEATS, -1);
    tick();
    tick();
  endtask

`ifdef DCACHE_REFILL_TIMEOUT_EN
  task automatic test_timeout();
    int cnt;
    bit seen;
    req_valid = 4'b0100;
    expect_refill(2, 1);
    wait_grant();
    tick();
    req_valid = '0;
    tick();
    cnt  = 0;
    seen = 1'b0;
    while (cnt < 300 && !seen) begin
      @(negedge clock);
      if (done_valid === 1'b1) seen = 1'b1;
      else cnt++;
    end
    n_total++;
    if (!seen || cnt < 254 || cnt > 256)
      $display("FAIL timeout_done: got seen=%b after %0d cycles expected 1 after ~255", seen, cnt);
    else n_pass++;
    n_total++;
    if (err !== 1'b1) $display("FAIL timeout_err: got %b expected 1", err);
    else n_pass++;
    tick();
    @(negedge clock);
    n_total++;
    if (busy !== 1'b0) $display("FAIL timeout_idle: got busy=%b expected 0", busy);
    else n_pass++;
    tick();
  endtask
`endif

  initial begin
    t_tag[0] = 20'h0ABCD; t_idx[0] = 6'h3F; t_way[0] = 3'd7;
    t_tag[1] = 20'h11111; t_idx[1] = 6'h01; t_way[1] = 3'd0;
    t_tag[2] = 20'h12345; t_idx[2] = 6'h05; t_way[2] = 3'd3;
    t_tag[3] = 20'hFEDCB; t_idx[3] = 6'h2A; t_way[3] = 3'd5;
    for (int i = 0; i < N; i++) begin
      req_tag[i*TAGB +: TAGB] = t_tag[i];
      req_idx[i*IDXB +: IDXB] = t_idx[i];
      req_way[i*WAYB +: WAYB] = t_way[i];
    end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrong_id();
    test_reset_mid();
`ifdef DCACHE_REFILL_TIMEOUT_EN
    test_timeout();
`endif
    n_total++;
    if (q_grant.size() + q_acq.size() + q_wr.size() + q_done.size() != 0)
      $display("FAIL leftover: got %0d/%0d/%0d/%0d pending expected 0/0/0/0",
               q_grant.size(), q_acq.size(), q_wr.size(), q_done.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish before 200000");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

endmodule
